// File: rtl/uart_mem_loader.sv
// UART byte stream to 16-bit memory write loader; optional trailing XOR checksum under UART_LOADER_CHKSUM_EN.
// Strobes are registered one cycle after the triggering rx_valid; one byte accepted per cycle, no backpressure.
module uart_mem_loader #(
  parameter int MAX_WORDS      = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [15:0]       uart_mem,
  output logic              uart_mem_en,
  output logic [ADDR_W-1:0] uart_addr,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = ADDR_W + 1;
  localparam logic [7:0]    MAX_B    = 8'(MAX_WORDS);
  localparam logic [7:0]    SYNC     = 8'hA5;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [NW-1:0] N_ONE    = NW'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CHK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [NW-1:0]     n_q, n_d;
  logic [7:0]        hi_q, hi_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       mem_q, mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    hi_d    = hi_q;
    mem_d   = mem_q;
    addr_d  = addr_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
    csum_d  = csum_q;
`endif
    if (state_q == S_IDLE || rx_valid) tmo_d = '0;
    else                               tmo_d = tmo_q + TMO_ONE;

    case (state_q)
      S_IDLE: if (rx_valid && rx_data == SYNC) state_d = S_LEN;
      S_LEN: if (rx_valid) begin
        if (rx_data == 8'h00 || rx_data > MAX_B) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          n_d     = rx_data[NW-1:0];
          idx_d   = '0;
`ifdef UART_LOADER_CHKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_HI;
        end
      end
      S_HI: if (rx_valid) begin
        hi_d    = rx_data;
`ifdef UART_LOADER_CHKSUM_EN
        csum_d  = csum_q ^ rx_data;
`endif
        state_d = S_LO;
      end
      S_LO: if (rx_valid) begin
        mem_d  = {hi_q, rx_data};
        addr_d = idx_q;
        en_d   = 1'b1;
`ifdef UART_LOADER_CHKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        // Compare against N-1 so the index stops at MAX_WORDS-1 and never wraps
        if ({1'b0, idx_q} == n_q - N_ONE) begin
`ifdef UART_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_HI;
        end
      end
`ifdef UART_LOADER_CHKSUM_EN
      S_CHK: if (rx_valid) begin
        if (rx_data == csum_q) done_d = 1'b1;
        else                   err_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // An arriving byte in the expiry cycle keeps the packet alive
    if (state_q != S_IDLE && !rx_valid && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      hi_q    <= '0;
      tmo_q   <= '0;
      mem_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      tmo_q   <= tmo_d;
      mem_q   <= mem_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UART_LOADER_CHKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign uart_mem    = mem_q;
  assign uart_addr   = addr_q;
  assign uart_mem_en = en_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

UART-to-data-memory loader that sits directly upstream of the memory stage and drives its `uart_mem` / `uart_mem_en` inputs. It consumes the byte stream from the UART receiver, frames it as a load packet, assembles big-endian 16-bit words and issues one single-cycle write strobe per word, with a word address. It also reports packet completion or error to the host-control logic.

## Interface
Parameters:
- `MAX_WORDS`, 16: maximum words per packet; equals data-memory depth.
- `ADDR_W`, 4: width of `uart_addr`; log2(`MAX_WORDS`).
- `TIMEOUT_CYCLES`, 100000: maximum idle gap, in clock cycles, between bytes inside a packet.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe from the UART receiver.
- `uart_mem` out 16: assembled word to be written to memory.
- `uart_mem_en` out 1: one-cycle write strobe for `uart_mem`.
- `uart_addr` out `ADDR_W`: word index for the current `uart_mem`.
- `busy` out 1: high whenever a packet is in progress (state ≠ IDLE).
- `load_done` out 1: one-cycle pulse when a packet completes successfully.
- `load_err` out 1: one-cycle pulse when a packet is aborted.

## Operation
- Packet format: `0xA5` sync, length byte N, 2N data bytes (high byte first per word), then a checksum byte if the checksum feature is compiled in.
- States:
  - IDLE: waits for a byte equal to `0xA5`, then goes to LEN. All other bytes are ignored with no error.
  - LEN: a length byte with N in 1..`MAX_WORDS` latches N, clears the word index and checksum accumulator, then goes to HI. N = 0 or N > `MAX_WORDS` pulses `load_err` and returns to IDLE.
  - HI: latches the byte as the high byte, then goes to LO.
  - LO: registers `uart_mem` = {hi, byte}, `uart_addr` = index, and pulses `uart_mem_en`.
    - If index = N−1, goes to CHK (or finishes directly without the checksum feature).
    - Otherwise increments the index and goes to HI.
  - CHK: compares the byte to the XOR of all 2N data bytes.
    - Match: pulses `load_done`.
    - Mismatch: pulses `load_err`.
    - Either way, returns to IDLE.
- Checksum accumulator: XORs every data byte as it is accepted in HI and LO.
- Timeout counter:
  - Clears on every accepted `rx_valid` and while in IDLE.
  - Counts otherwise.
  - Reaching `TIMEOUT_CYCLES` pulses `load_err` and forces IDLE.
- Words already written before an abort are not rolled back.
- `uart_mem` and `uart_addr` hold their last value between strobes.

## Timing
- Reset value of every output is 0. State resets to IDLE; index, N, accumulator and timeout counter reset to 0.
- Latency: `uart_mem_en`, `load_done` and `load_err` are asserted in the cycle after the `rx_valid` that triggers them.
- All three strobes are exactly one cycle wide. `uart_mem_en` and `load_done` never assert in the same cycle.
- The block accepts one byte per cycle: back-to-back `rx_valid` on consecutive cycles must be handled with no loss.
- `busy` rises the cycle after sync is accepted and falls in the same cycle that `load_done` or `load_err` pulses.
- Simultaneous events:
  - If `rx_valid` arrives in the cycle the timeout would expire, the byte wins; the counter clears and there is no error.
  - Index wrap: with N = `MAX_WORDS`, the final write uses `uart_addr` = `MAX_WORDS`−1. The index never wraps to 0 within a packet.
- `reset` asserted mid-packet: IDLE on the next edge, no strobe issued, and the partial word is discarded.

## Configuration
- Macro: `UART_LOADER_CHKSUM_EN`.
- Defined:
  - The CHK state and the trailing checksum byte are required.
  - A mismatch gives `load_err`.
- Undefined:
  - No checksum byte and no accumulator logic.
  - After the last LO write, `load_done` pulses in the same cycle as the final `uart_mem_en`. This is the single permitted exception to the no-overlap rule.
  - The block returns to IDLE.

## Test plan
- Normal load, macro on: bytes A5 02 12 34 AB CD 40.
  - Writes 0x1234 at addr 0, then 0xABCD at addr 1, each as a one-cycle `uart_mem_en`.
  - `load_done` pulses one cycle after byte 40; `load_err` stays 0.
- Bad checksum, macro on: same packet ending in 41.
  - Both writes occur, then `load_err` pulses.
  - `busy` is 0 the following cycle.
- Length bounds:
  - A5 00 gives `load_err` and no writes.
  - A5 11 gives `load_err`.
  - A5 10 followed by 32 bytes gives 16 writes; the last uses `uart_addr` = 15.
- Timeout: A5 01 12, then no `rx_valid` for `TIMEOUT_CYCLES` cycles → `load_err` pulses, no write, state returns to IDLE.
  - A following A5 01 00 07 07 loads 0x0007 at addr 0 with `load_done`.
- Reset mid-packet: A5 02 12, then `reset` for 1 cycle, then bytes 34 AB.
  - No `uart_mem_en`, all outputs 0, and bytes 34 AB are ignored in IDLE.
- Noise and back-to-back input: junk bytes 00 FF 5A before A5 cause no error; all packet bytes are delivered on consecutive cycles and every word is written correctly.
